// File: rtl/micro_hash_miner.sv
// micro_hash_miner
// Nonce-search engine. Hashes a 12-byte header plus a 4-byte nonce with a
// 24-bit micro-hash, one round per clock. It compares the hash against an
// 8-bit target and steps the nonce until it finds a hit or runs out of tries.
//
// Ports
//   clk            in   1   system clock, rising edge
//   reset          in   1   asynchronous, active-low reset
//   selector       in   1   search enable (level): raise to start, drop to abort
//   data_entry_12  in  96   header bytes B0..B11, B0 = [95:88]
//   data_nonce     in  32   start nonce N0..N3, N0 = [31:24]
//   data_target    in   8   difficulty target
//   data_out_cond  out 24   last hash {H0,H1,H2}
//   nonce_out      out 32   nonce that produced data_out_cond
//   hash_valid     out  1   one-cycle pulse when data_out_cond/nonce_out update
//   found          out  1   high in DONE when the search hit the target
//   done           out  1   high in DONE
//   state_dbg      out  3   current FSM state (IDLE=0 LOAD=1 ROUND=2 CHECK=3 DONE=4)
//
// Handshake: selector is a level-sensitive request with no ready. The inputs
// are sampled only on the IDLE edge that sees selector=1. Dropping selector
// before DONE aborts without a result. hash_valid is an unqualified one-cycle
// strobe: the consumer must take data_out_cond/nonce_out in that cycle and
// cannot stall the engine.
module micro_hash_miner #(
  parameter int ROUNDS    = 32,
  parameter int MAX_TRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selector,
  input  logic [95:0] data_entry_12,
  input  logic [31:0] data_nonce,
  input  logic [7:0]  data_target,
  output logic [23:0] data_out_cond,
  output logic [31:0] nonce_out,
  output logic        hash_valid,
  output logic        found,
  output logic        done,
  output logic [2:0]  state_dbg
);

  localparam int TRY_W = 17;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [95:0]         hdr_q, hdr_d;
  logic [7:0]          target_q, target_d;
  logic [31:0]         nonce_q, nonce_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [15:0][7:0]    win_q, win_d;
  logic [7:0]          a_q, a_d, b_q, b_d, c_q, c_d;
  logic [4:0]          rnd_q, rnd_d;
  logic [23:0]         data_out_cond_q, data_out_cond_d;
  logic [31:0]         nonce_out_q, nonce_out_d;
  logic                hash_valid_q, hash_valid_d;
  logic                found_q, found_d;
  logic                done_q, done_d;

  // Round datapath and hash finalisation
  logic [127:0]        hn;
  logic [7:0]          k_cur, x_cur, w_next;
  logic [7:0]          h0, h1, h2;
  logic                hit;
  logic [TRY_W-1:0]    tries_inc;

  assign hn = {hdr_q, nonce_q};

  always_comb begin
    // The first 17 rounds (i = 0..16) use the XOR mixer, the rest use OR.
    if (rnd_q <= 5'd16) begin
      k_cur = 8'h99;
      x_cur = a_q ^ b_q;
    end else begin
      k_cur = 8'hA1;
      x_cur = a_q | b_q;
    end
    // win_q[j] holds W[i+j] during round i. The word shifted in now is
    // W[i+16] = W[i+13] | (W[i+7] ^ W[i+2]). Words past W[31] are generated
    // but never consumed.
    w_next    = win_q[13] | (win_q[7] ^ win_q[2]);
    h0        = 8'h01 + a_q;
    h1        = 8'h89 + b_q;
    h2        = 8'hFE + c_q;
    hit       = (h0 < target_q) && (h1 < target_q);
    tries_inc = tries_q + 1'b1;
  end

  always_comb begin
    state_d         = state_q;
    hdr_d           = hdr_q;
    target_d        = target_q;
    nonce_d         = nonce_q;
    tries_d         = tries_q;
    win_d           = win_q;
    a_d             = a_q;
    b_d             = b_q;
    c_d             = c_q;
    rnd_d           = rnd_q;
    data_out_cond_d = data_out_cond_q;
    nonce_out_d     = nonce_out_q;
    hash_valid_d    = 1'b0;
    found_d         = found_q;
    done_d          = done_q;

    case (state_q)
      S_IDLE: begin
        if (selector) begin
          hdr_d    = data_entry_12;
          target_d = data_target;
          nonce_d  = data_nonce;
          tries_d  = '0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!selector) begin
          state_d = S_IDLE;
        end else begin
          for (int j = 0; j < 16; j++) begin
            win_d[j] = hn[127-8*j -: 8];
          end
          a_d     = 8'h01;
          b_d     = 8'h89;
          c_d     = 8'hFE;
          rnd_d   = 5'd0;
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        if (!selector) begin
          state_d = S_IDLE;
        end else begin
          a_d           = b_q ^ c_q;
          b_d           = {c_q[3:0], 4'h0};
          c_d           = x_cur + k_cur + win_q[0];
          win_d[14:0]   = win_q[15:1];
          win_d[15]     = w_next;
          if (rnd_q == 5'(ROUNDS - 1)) begin
            state_d = S_CHECK;
          end else begin
            rnd_d = rnd_q + 5'd1;
          end
        end
      end

      S_CHECK: begin
        // An abort on this edge wins over publishing the result.
        if (!selector) begin
          state_d = S_IDLE;
        end else begin
          data_out_cond_d = {h0, h1, h2};
          nonce_out_d     = nonce_q;
          hash_valid_d    = 1'b1;
          if (hit) begin
            found_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TRY_W'(MAX_TRIES)) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              nonce_d = nonce_q + 32'd1;
              state_d = S_LOAD;
            end
          end
        end
      end

      S_DONE: begin
        if (!selector) begin
          found_d = 1'b0;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      hdr_q           <= '0;
      target_q        <= '0;
      nonce_q         <= '0;
      tries_q         <= '0;
      win_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      c_q             <= '0;
      rnd_q           <= '0;
      data_out_cond_q <= '0;
      nonce_out_q     <= '0;
      hash_valid_q    <= 1'b0;
      found_q         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      hdr_q           <= hdr_d;
      target_q        <= target_d;
      nonce_q         <= nonce_d;
      tries_q         <= tries_d;
      win_q           <= win_d;
      a_q             <= a_d;
      b_q             <= b_d;
      c_q             <= c_d;
      rnd_q           <= rnd_d;
      data_out_cond_q <= data_out_cond_d;
      nonce_out_q     <= nonce_out_d;
      hash_valid_q    <= hash_valid_d;
      found_q         <= found_d;
      done_q          <= done_d;
    end
  end

  assign data_out_cond = data_out_cond_q;
  assign nonce_out     = nonce_out_q;
  assign hash_valid    = hash_valid_q;
  assign found         = found_q;
  assign done          = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_micro_hash_miner.sv
// tb_micro_hash_miner
// Bench for micro_hash_miner. Driver tasks issue searches and push one
// expected {edge, hash, nonce} entry per nonce the engine should try. A
// separate monitor pops an entry on every hash_valid pulse and compares it.
module tb_micro_hash_miner;

  localparam int MAX_TRIES = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ROUND = 3'd2;

  localparam logic [95:0] GOLD_HDR = 96'h397d9f2f40ca9e6c6b1f3324;

  logic        clk;
  logic        reset;
  logic        selector;
  logic [95:0] data_entry_12;
  logic [31:0] data_nonce;
  logic [7:0]  data_target;
  logic [23:0] data_out_cond;
  logic [31:0] nonce_out;
  logic        hash_valid;
  logic        found;
  logic        done;
  logic [2:0]  state_dbg;

  micro_hash_miner #(.ROUNDS(32), .MAX_TRIES(MAX_TRIES)) dut (
    .clk           (clk),
    .reset         (reset),
    .selector      (selector),
    .data_entry_12 (data_entry_12),
    .data_nonce    (data_nonce),
    .data_target   (data_target),
    .data_out_cond (data_out_cond),
    .nonce_out     (nonce_out),
    .hash_valid    (hash_valid),
    .found         (found),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / edge counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] edge_cnt = 32'd0;
  always @(posedge clk) edge_cnt = edge_cnt + 32'd1;

  // ---------------- scoreboard ----------------
  logic [87:0] exp_q[$];
  logic [55:0] last_exp;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [87:0] got, input logic [87:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference micro-hash built straight from the recurrence, with a full
  // 32-word schedule.
  function automatic logic [23:0] model_hash(input logic [95:0] hdr, input logic [31:0] n);
    logic [7:0] w[32];
    logic [7:0] a, b, c, k, x, na, nb, nc;
    for (int j = 0; j < 12; j++) w[j] = hdr[95-8*j -: 8];
    for (int j = 0; j < 4; j++)  w[12+j] = n[31-8*j -: 8];
    for (int j = 16; j < 32; j++) w[j] = w[j-3] | (w[j-9] ^ w[j-14]);
    a = 8'h01; b = 8'h89; c = 8'hFE;
    for (int i = 0; i < 32; i++) begin
      if (i <= 16) begin k = 8'h99; x = a ^ b; end
      else         begin k = 8'hA1; x = a | b; end
      na = b ^ c;
      nb = c << 4;
      nc = x + k + w[i];
      a = na; b = nb; c = nc;
    end
    return {8'h01 + a, 8'h89 + b, 8'hFE + c};
  endfunction

  // Monitor: every pulse must match the oldest expected entry, edge included.
  always @(negedge clk) begin
    if (reset && hash_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_hash_valid: got nonce %h hash %h at edge %0d, expected no pulse",
                 nonce_out, data_out_cond, edge_cnt);
      end else begin
        check("hash_pulse{edge,hash,nonce}", {edge_cnt, data_out_cond, nonce_out}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_inputs(input logic [95:0] hdr, input logic [31:0] n, input logic [7:0] tgt);
    data_entry_12 = hdr;
    data_nonce    = n;
    data_target   = tgt;
    selector      = 1'b1;
  endtask

  // s_edge is the edge that samples selector=1; the result of nonce k
  // appears after edge s_edge + 34*(k+1).
  task automatic plan_expect(input logic [31:0] s_edge, input logic [95:0] hdr,
                             input logic [31:0] n0, input logic [7:0] tgt,
                             output logic exp_found, output logic [31:0] done_edge);
    logic [31:0] n;
    logic [23:0] h;
    logic [31:0] e_edge;
    logic        hit;
    n = n0;
    hit = 1'b0;
    done_edge = s_edge + 32'(34 * MAX_TRIES);
    for (int k = 0; k < MAX_TRIES && !hit; k++) begin
      h = model_hash(hdr, n);
      e_edge = s_edge + 32'(34 * (k + 1));
      exp_q.push_back({e_edge, h, n});
      last_exp = {h, n};
      if ((h[23:16] < tgt) && (h[15:8] < tgt)) begin
        hit = 1'b1;
        done_edge = e_edge;
      end
      n = n + 32'd1;
    end
    exp_found = hit;
  endtask

  task automatic wait_done(input string name, input logic exp_found, input logic [31:0] done_edge);
    int cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles, expected done=1", name, cyc);
    end else begin
      check({name, "_done_edge"}, done_edge == 32'd0 ? 88'd0 : {56'd0, edge_cnt}, {56'd0, done_edge});
      check({name, "_found"}, {87'd0, found}, {87'd0, exp_found});
    end
    @(negedge clk);
    check({name, "_queue_drained"}, 88'(exp_q.size()), 88'd0);
  endtask

  task automatic finish_search(input string name);
    selector = 1'b0;
    @(negedge clk);
    check({name, "_idle_state"}, {85'd0, state_dbg}, {85'd0, ST_IDLE});
    check({name, "_idle_flags"}, {86'd0, done, found}, 88'd0);
    check({name, "_retained_out"}, {32'd0, data_out_cond, nonce_out}, {32'd0, last_exp});
    exp_q.delete();
  endtask

  task automatic run_search(input string name, input logic [95:0] hdr,
                            input logic [31:0] n, input logic [7:0] tgt);
    logic        ef;
    logic [31:0] de;
    @(negedge clk);
    drive_inputs(hdr, n, tgt);
    plan_expect(edge_cnt + 32'd1, hdr, n, tgt, ef, de);
    wait_done(name, ef, de);
    finish_search(name);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    logic        ef;
    logic [31:0] de;
    logic [31:0] s_edge;
    int          cyc;

    reset         = 1'b0;
    selector      = 1'b1;
    data_entry_12 = GOLD_HDR;
    data_nonce    = 32'hfded873c;
    data_target   = 8'hff;
    last_exp      = '0;

    // Reset held with selector=1: everything stays at zero in IDLE.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state",      {85'd0, state_dbg}, {85'd0, ST_IDLE});
    check("reset_data_out",   {64'd0, data_out_cond}, 88'd0);
    check("reset_nonce_out",  {56'd0, nonce_out}, 88'd0);
    check("reset_flags",      {85'd0, hash_valid, found, done}, 88'd0);

    // Golden search: starts on the first edge after reset release.
    plan_expect(edge_cnt + 32'd1, GOLD_HDR, 32'hfded873c, 8'hff, ef, de);
    reset = 1'b1;
    wait_done("golden", ef, de);
    finish_search("golden");

    // Exhaustion: target 00 never hits; 16 pulses, done 545 edges in.
    run_search("exhaust", GOLD_HDR, 32'hfded873c, 8'h00);

    // A mid-range target to exercise misses followed by a hit.
    run_search("midtarget", 96'h0123456789abcdef00112233, 32'h12345678, 8'h80);

    // Nonce wrap: second nonce_out is 00000000.
    run_search("wrap", GOLD_HDR, 32'hffffffff, 8'h00);

    // Abort during the round-20 cycle.
    @(negedge clk);
    drive_inputs(GOLD_HDR, 32'h0badf00d, 8'h00);
    s_edge = edge_cnt + 32'd1;
    cyc = 0;
    while (edge_cnt != s_edge + 32'd21 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_in_round", {85'd0, state_dbg}, {85'd0, ST_ROUND});
    selector = 1'b0;
    @(negedge clk);
    check("abort_idle", {85'd0, state_dbg}, {85'd0, ST_IDLE});
    check("abort_flags", {86'd0, done, found}, 88'd0);
    repeat (40) @(negedge clk);
    // Re-raise: the newly sampled nonce is used.
    run_search("restart", GOLD_HDR, 32'h00c0ffee, 8'hff);

    // Asynchronous reset in the middle of ROUND.
    @(negedge clk);
    drive_inputs(GOLD_HDR, 32'h55aa55aa, 8'h00);
    s_edge = edge_cnt + 32'd1;
    cyc = 0;
    while (edge_cnt != s_edge + 32'd10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    #2 reset = 1'b0;
    #1;
    check("async_reset_state", {85'd0, state_dbg}, {85'd0, ST_IDLE});
    check("async_reset_outs",  {32'd0, data_out_cond, nonce_out}, 88'd0);
    check("async_reset_flags", {85'd0, hash_valid, found, done}, 88'd0);
    @(negedge clk);
    // Selector stays high: a fresh search begins on the first edge after release.
    data_nonce  = 32'h13572468;
    data_target = 8'hff;
    plan_expect(edge_cnt + 32'd1, GOLD_HDR, 32'h13572468, 8'hff, ef, de);
    reset = 1'b1;
    wait_done("after_reset", ef, de);
    finish_search("after_reset");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of test before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
